// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and the feeder FSM state type for the MAC array
// feeder and its operand buffer.
package mac_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ROWS       = 8;
    localparam int DEFAULT_DEPTH      = 8;

    // Each MAC row accumulates into a sum three operands wide.
    localparam int ACC_WIDTH = 3 * DEFAULT_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feederState_e;

endpackage

// File: rtl/mac_operand_buffer.sv
// mac_operand_buffer: holds the A matrix (ROWS x DEPTH) and the B vector
// (DEPTH). Writes are decoded from a single write port. Reads are
// combinational: one A element per row (each row has its own column) plus
// one B element.
module mac_operand_buffer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wrEn_i,
    input  logic                          wrSel_i,
    input  logic [$clog2(ROWS)-1:0]       wrRow_i,
    input  logic [$clog2(DEPTH)-1:0]      wrCol_i,
    input  logic [DATA_WIDTH-1:0]         wrData_i,
    input  logic [ROWS*$clog2(DEPTH)-1:0] rdColA_i,
    output logic [ROWS*DATA_WIDTH-1:0]    rdDataA_o,
    input  logic [$clog2(DEPTH)-1:0]      rdColB_i,
    output logic [DATA_WIDTH-1:0]         rdDataB_o
);

    localparam int COL_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] aMem_q [ROWS][DEPTH];
    logic [DATA_WIDTH-1:0] bMem_q [DEPTH];

    logic rowInRange;
    logic colInRange;

    // Range-check the write address; only matters for non-power-of-2 sizes.
    always_comb begin
        rowInRange = (int'(wrRow_i) < ROWS);
        colInRange = (int'(wrCol_i) < DEPTH);
    end

    // Operand storage: cleared on reset, written one element per accepted strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    aMem_q[r][k] <= '0;
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                bMem_q[k] <= '0;
            end
        end else if (wrEn_i && colInRange) begin
            if (wrSel_i) begin
                bMem_q[wrCol_i] <= wrData_i;
            end else if (rowInRange) begin
                aMem_q[wrRow_i][wrCol_i] <= wrData_i;
            end
        end
    end

    // Combinational read: every row looks up its own column; B has one column.
    always_comb begin
        rdDataA_o = '0;
        rdDataB_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(rdColA_i[r*COL_W +: COL_W]) < DEPTH) begin
                rdDataA_o[r*DATA_WIDTH +: DATA_WIDTH] = aMem_q[r][rdColA_i[r*COL_W +: COL_W]];
            end
        end
        if (int'(rdColB_i) < DEPTH) begin
            rdDataB_o = bMem_q[rdColB_i];
        end
    end

endmodule

// File: rtl/mac_array_feeder.sv
// mac_array_feeder: sequences one matrix-vector pass into the MAC array.
// It clears the accumulators, then streams skewed A operands and the B vector,
// drains one cycle so the last accumulate lands, and pulses done.
// Every output is registered, so each output lags the FSM state by one cycle.
module mac_array_feeder
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [$clog2(ROWS)-1:0]    wr_row,
    input  logic [$clog2(DEPTH)-1:0]   wr_col,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       clr_out,
    output logic [ROWS-1:0]            en_out,
    output logic [ROWS*DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0]      b_out
);

    localparam int COL_W = $clog2(DEPTH);
    localparam int T_LEN = DEPTH + ROWS - 1;
    localparam int T_W   = $clog2(DEPTH + ROWS);

    feederState_e state_q, state_d;
    logic [T_W-1:0] tCount_q, tCount_d;

    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       clr_q, clr_d;
    logic [ROWS-1:0]            en_q, en_d;
    logic [ROWS*DATA_WIDTH-1:0] aOut_q, aOut_d;
    logic [DATA_WIDTH-1:0]      bOut_q, bOut_d;

    logic                       writeOpen;
    logic                       bValid;
    logic [ROWS*COL_W-1:0]      rdColA;
    logic [ROWS*DATA_WIDTH-1:0] rdDataA;
    logic [COL_W-1:0]           rdColB;
    logic [DATA_WIDTH-1:0]      rdDataB;

    // Writes land only while truly idle: FSM in IDLE and busy already low.
    always_comb begin
        writeOpen = (state_q == IDLE) && !busy_q;
    end

    mac_operand_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ROWS),
        .DEPTH      (DEPTH)
    ) operandBuffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrEn_i    (wr_en && writeOpen),
        .wrSel_i   (wr_sel),
        .wrRow_i   (wr_row),
        .wrCol_i   (wr_col),
        .wrData_i  (wr_data),
        .rdColA_i  (rdColA),
        .rdDataA_o (rdDataA),
        .rdColB_i  (rdColB),
        .rdDataB_o (rdDataB)
    );

    // FSM state and stream counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tCount_q <= '0;
        end else begin
            state_q  <= state_d;
            tCount_q <= tCount_d;
        end
    end

    // Next-state logic: one clear cycle, T stream steps, one drain, one done.
    always_comb begin
        state_d  = state_q;
        tCount_d = tCount_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d  = STREAM;
                tCount_d = '0;
            end
            STREAM: begin
                if (tCount_q == T_W'(T_LEN - 1)) begin
                    state_d = DRAIN;
                end else begin
                    tCount_d = tCount_q + T_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Skew decode: row r is active for r <= t < r+DEPTH and reads column t-r.
    always_comb begin
        int tInt;
        tInt   = int'(tCount_q);
        en_d   = '0;
        rdColA = '0;
        rdColB = '0;
        bValid = 1'b0;
        clr_d  = (state_q == CLEAR);
        done_d = (state_q == DONE);
        busy_d = (state_q != IDLE);
        if (state_q == STREAM) begin
            for (int r = 0; r < ROWS; r++) begin
                if ((tInt >= r) && (tInt < r + DEPTH)) begin
                    en_d[r]                    = 1'b1;
                    rdColA[r*COL_W +: COL_W] = COL_W'(tInt - r);
                end
            end
            if (tInt < DEPTH) begin
                bValid = 1'b1;
                rdColB = COL_W'(tInt);
            end
        end
    end

    // Operand muxing: inactive rows and the B tail are forced to zero.
    always_comb begin
        aOut_d = '0;
        bOut_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (en_d[r]) begin
                aOut_d[r*DATA_WIDTH +: DATA_WIDTH] = rdDataA[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (bValid) begin
            bOut_d = rdDataB;
        end
    end

    // Output registers; reset drives every output low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            en_q   <= '0;
            aOut_q <= '0;
            bOut_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            clr_q  <= clr_d;
            en_q   <= en_d;
            aOut_q <= aOut_d;
            bOut_q <= bOut_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign clr_out = clr_q;
    assign en_out  = en_q;
    assign a_out   = aOut_q;
    assign b_out   = bOut_q;

endmodule

// File: tb/tb_mac_array_feeder.sv
// tb_mac_array_feeder: directed bench with a pass-level behavioural model,
// a per-cycle output compare, a MAC-array scoreboard, and hand-computed checks.
module tb_mac_array_feeder;

    import mac_pkg::*;

    localparam int DW    = DEFAULT_DATA_WIDTH;
    localparam int ROWS  = DEFAULT_ROWS;
    localparam int DEPTH = DEFAULT_DEPTH;
    localparam int T_LEN = DEPTH + ROWS - 1;
    localparam int LAT   = ROWS + DEPTH + 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 wr_en = 1'b0;
    logic                 wr_sel = 1'b0;
    logic [2:0]           wr_row = '0;
    logic [2:0]           wr_col = '0;
    logic [DW-1:0]        wr_data = '0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 clr_out;
    logic [ROWS-1:0]      en_out;
    logic [ROWS*DW-1:0]   a_out;
    logic [DW-1:0]        b_out;

    int errors = 0;
    int checks = 0;

    // Pass-level model: operand copies plus the cycle index since start.
    int  modelA [ROWS][DEPTH];
    int  modelB [DEPTH];
    bit  active = 1'b0;
    int  passCyc = 0;

    // MAC array scoreboard and done pulse counter.
    longint acc [ROWS];
    int     bHist [ROWS];
    int     doneCount = 0;

    logic                 expBusy, expDone, expClr;
    logic [ROWS-1:0]      expEn;
    logic [ROWS*DW-1:0]   expA;
    logic [DW-1:0]        expB;

    always #5 clk = ~clk;

    mac_array_feeder #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .clr_out (clr_out),
        .en_out  (en_out),
        .a_out   (a_out),
        .b_out   (b_out)
    );

    task automatic checkValue(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input logic eBusy, input logic eDone, input logic eClr,
                               input logic [ROWS-1:0] eEn, input logic [ROWS*DW-1:0] eA,
                               input logic [DW-1:0] eB);
        checks++;
        if ({busy, done, clr_out, en_out, a_out, b_out} !== {eBusy, eDone, eClr, eEn, eA, eB}) begin
            errors++;
            $display("[TB] FAIL cycleCompare @%0t: got busy=%b done=%b clr=%b en=%h a=%h b=%h, expected busy=%b done=%b clr=%b en=%h a=%h b=%h",
                     $time, busy, done, clr_out, en_out, a_out, b_out, eBusy, eDone, eClr, eEn, eA, eB);
        end
    endtask

    // Model update: writes accepted only outside a pass, start accepted from idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    modelA[r][k] = 0;
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                modelB[k] = 0;
            end
            active  = 1'b0;
            passCyc = 0;
        end else begin
            if (wr_en && (!active || passCyc > LAT)) begin
                if (wr_sel) begin
                    modelB[wr_col] = int'(wr_data);
                end else begin
                    modelA[wr_row][wr_col] = int'(wr_data);
                end
            end
            if (start && (!active || passCyc >= LAT)) begin
                active  = 1'b1;
                passCyc = 0;
            end else if (active && passCyc < 1000) begin
                passCyc++;
            end
        end
    end

    // Compare the DUT against the model every cycle, then update the MAC scoreboard.
    always @(negedge clk) begin
        expBusy = 1'b0;
        expDone = 1'b0;
        expClr  = 1'b0;
        expEn   = '0;
        expA    = '0;
        expB    = '0;
        if (rst_n && active) begin
            expBusy = (passCyc >= 1) && (passCyc <= LAT);
            expClr  = (passCyc == 1);
            expDone = (passCyc == LAT);
            if ((passCyc >= 2) && (passCyc < 2 + T_LEN)) begin
                for (int r = 0; r < ROWS; r++) begin
                    int k;
                    k = passCyc - 2 - r;
                    if ((k >= 0) && (k < DEPTH)) begin
                        expEn[r] = 1'b1;
                        expA[r*DW +: DW] = DW'(modelA[r][k]);
                    end
                end
                if (passCyc - 2 < DEPTH) begin
                    expB = DW'(modelB[passCyc - 2]);
                end
            end
        end
        checkOutput(expBusy, expDone, expClr, expEn, expA, expB);

        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                acc[r]   = 0;
                bHist[r] = 0;
            end
        end else begin
            for (int r = ROWS - 1; r > 0; r--) begin
                bHist[r] = bHist[r-1];
            end
            bHist[0] = int'(b_out);
            for (int r = 0; r < ROWS; r++) begin
                if (clr_out) begin
                    acc[r] = 0;
                end else if (en_out[r]) begin
                    acc[r] = acc[r] + longint'(a_out[r*DW +: DW]) * longint'(bHist[r]);
                end
            end
            if (done) begin
                doneCount++;
            end
        end
    end

    task automatic applyStimulus(input bit wEn, input bit wSel, input int wRow, input int wCol,
                                 input int wData, input bit st);
        wr_en   = wEn;
        wr_sel  = wSel;
        wr_row  = 3'(wRow);
        wr_col  = 3'(wCol);
        wr_data = DW'(wData);
        start   = st;
        @(posedge clk);
        #1;
    endtask

    // Load A[r][k]=r+1 and B[k]=k+1; optionally leave B[DEPTH-1] for a later write.
    task automatic loadPattern(input bit skipLastB);
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                applyStimulus(1, 0, r, k, r + 1, 0);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (!(skipLastB && k == DEPTH - 1)) begin
                applyStimulus(1, 1, 0, k, k + 1, 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    // One pass from a start pulse; returns the cycle of the done pulse or -1.
    task automatic runPass(input bit wEn, input bit wSel, input int wCol, input int wData,
                           input bit skew, output int doneCyc);
        doneCyc = -1;
        applyStimulus(wEn, wSel, 0, wCol, wData, 1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (skew) begin
                if (cyc == 1)  checkValue("clrCycle1", clr_out, 1);
                if (cyc == 2)  checkValue("enCycle2", en_out, 8'h01);
                if (cyc == 5) begin
                    checkValue("skewEnT3", en_out, 8'h0F);
                    checkValue("skewBT3", b_out, 4);
                    checkValue("skewRow2T3", a_out[2*DW +: DW], 3);
                    checkValue("skewRow4T3", a_out[4*DW +: DW], 0);
                end
                if (cyc == 9)  checkValue("enCycle9", en_out, 8'hFF);
                if (cyc == 16) checkValue("enCycle16", en_out, 8'h80);
                if (cyc == 17) checkValue("enDrain", en_out, 8'h00);
            end
            if (done === 1'b1) begin
                doneCyc = cyc;
                break;
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkSums(input string tag, input bit scaled, input longint base);
        for (int r = 0; r < ROWS; r++) begin
            checkValue($sformatf("%s sum row%0d", tag, r), acc[r], scaled ? longint'(r + 1) * base : base);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc;
        int doneSnap;
        int firstDone;
        int secondDone;

        $display("[TB] reset with random inputs");
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 1));
        end
        checkValue("resetBusy", busy, 0);
        checkValue("resetDone", done, 0);
        checkValue("resetClr", clr_out, 0);
        checkValue("resetEn", en_out, 0);
        checkValue("resetA", a_out, 0);
        checkValue("resetB", b_out, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] pass with empty buffers");
        runPass(0, 0, 0, 0, 0, dc);
        checkValue("emptyDoneLatency", dc, LAT);
        checkSums("empty", 0, 0);

        $display("[TB] basic pass, last B write shares the start cycle");
        loadPattern(1);
        runPass(1, 1, DEPTH - 1, DEPTH, 1, dc);
        checkValue("basicDoneLatency", dc, 18);
        checkSums("basic", 1, 36);

        $display("[TB] writes and start while busy are ignored");
        doneSnap = doneCount;
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 3)       applyStimulus(1, 0, 0, 0, 8'h55, 0);
            else if (cyc == 5)  applyStimulus(1, 1, 0, 0, 8'h55, 0);
            else if (cyc == 7)  applyStimulus(0, 0, 0, 0, 0, 1);
            else if (cyc == 10) applyStimulus(1, 0, 3, 3, 8'hAA, 1);
            else                applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkValue("protectDonePulses", doneCount - doneSnap, 1);
        runPass(0, 0, 0, 0, 0, dc);
        checkValue("protectDoneLatency", dc, LAT);
        checkSums("protect", 1, 36);

        $display("[TB] reset during stream");
        doneSnap = doneCount;
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        rst_n = 1'b0;
        #1;
        checkValue("midResetBusy", busy, 0);
        checkValue("midResetEn", en_out, 0);
        checkValue("midResetA", a_out, 0);
        checkValue("midResetB", b_out, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkValue("midResetNoDone", doneCount - doneSnap, 0);
        runPass(0, 0, 0, 0, 0, dc);
        checkValue("clearedDoneLatency", dc, LAT);
        checkSums("cleared", 0, 0);
        loadPattern(0);
        runPass(0, 0, 0, 0, 1, dc);
        checkValue("recoverDoneLatency", dc, 18);
        checkSums("recover", 1, 36);

        $display("[TB] extreme operands, start held high");
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                applyStimulus(1, 0, r, k, 8'hFF, 0);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1, 1, 0, k, 8'hFF, 0);
        end
        firstDone  = -1;
        secondDone = -1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            if (done === 1'b1) begin
                if (firstDone < 0) begin
                    firstDone = cyc;
                    checkSums("extremeFirst", 0, 520200);
                end else if (secondDone < 0) begin
                    secondDone = cyc;
                    checkSums("extremeSecond", 0, 520200);
                end
            end
        end
        checkValue("extremeFirstDone", firstDone, 18);
        checkValue("extremeDoneSpacing", secondDone - firstDone, 19);
        for (int i = 0; i < 25; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkValue("finalIdleBusy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_array_feeder.md
Name: mac_array_feeder

Overview:
- Upstream sequencer for the 8-bit MAC array: buffers an A matrix (ROWS x DEPTH) and a B vector (DEPTH) written over a simple write port.
- On start, clears the accumulators, then streams skewed operands into the array: row r gets its A data and En delayed by r cycles.
- This skew matches B travelling down the MAC chain one register per row.
- Signals completion once the last accumulate has landed, so downstream logic can read each row's 24-bit sum.

Parameters:
DATA_WIDTH, 8, operand width of A and B elements
ROWS, 8, number of MAC rows driven (one A stream and one En per row)
DEPTH, 8, vector length: elements accumulated per row

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
wr_en  input  1  write strobe for operand buffers
wr_sel  input  1  0 = write A buffer, 1 = write B buffer
wr_row  input  $clog2(ROWS)  A row index (ignored when wr_sel=1)
wr_col  input  $clog2(DEPTH)  element index
wr_data  input  DATA_WIDTH  write data
start  input  1  begin one matrix-vector pass (level sampled in IDLE)
busy  output  1  pass in progress
done  output  1  one-cycle pulse: all accumulations complete
clr_out  output  1  accumulator clear to all MAC rows
en_out  output  ROWS  per-row MAC enable; bit r drives row r
a_out  output  ROWS*DATA_WIDTH  per-row A operand; slice r drives row r
b_out  output  DATA_WIDTH  B operand into row 0 only; rows r>0 receive it from the MAC chain

Behaviour:
- Reset: every output is 0; the FSM is in IDLE; the A/B buffers and counters are cleared.
- Reset asserted mid-pass aborts immediately. No done pulse is produced.
- All outputs are registered.
- Writes: accepted only when busy=0; ignored while busy. Out-of-range wr_row/wr_col (non-power-of-2 params) are ignored.
- Write and start in the same IDLE cycle: the write commits first and the pass uses the new value.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: start=1 moves to CLEAR; busy rises in the next cycle.
- CLEAR: exactly one cycle with clr_out=1, en_out=0, then STREAM.
- STREAM: counter t runs 0..T-1 with T = DEPTH+ROWS-1.
  - en_out[r]=1 iff r <= t < r+DEPTH.
  - a_out slice r = A[r][t-r] when en_out[r]=1, otherwise 0.
  - b_out = B[t] for t < DEPTH, otherwise 0.
  - After t = T-1, go to DRAIN.
- DRAIN: one cycle with all en_out=0, so the final accumulate registers.
- DONE: done=1 for one cycle, busy=1, then IDLE with busy=0.
- Timing, with start sampled at edge 0 (ROWS=DEPTH=8):
  - clr_out high in cycle 1.
  - STREAM in cycles 2..16.
  - DRAIN in cycle 17.
  - done in cycle 18.
  - Total latency = ROWS+DEPTH+2 cycles.
- start while busy is ignored; there is no queued restart. start held high through DONE begins a new pass from IDLE on the following edge.
- The buffers persist across passes, so back-to-back passes reuse the data.
- Counter t has width $clog2(DEPTH+ROWS) and never wraps within a pass.

Decomposition:
- Shared package mac_pkg holds:
  - typedef for the FSM state enum
  - DATA_WIDTH, ROWS, DEPTH defaults
  - ACC_WIDTH = 3*DATA_WIDTH
- Natural sub-module: mac_operand_buffer, holding the A/B storage, write decode, and combinational read by (row, col).
- The FSM, skew logic and output registers remain in mac_array_feeder.

Test Plan:
- Reset: rst_n low with random inputs → all outputs 0; busy=0; buffers read 0 (a pass with no writes yields a_out=0 while en pulses).
- Basic pass: A[r][k]=r+1, B[k]=k+1, start pulse → clr_out in cycle 1; en_out[0] high in cycles 2-9; en_out[7] high in cycles 9-16; done in cycle 18. The scoreboard with a MAC model gives row r sum = (r+1)*36.
- Skew check: at stream t=3 → en_out=8'b0000_1111, b_out=B[3], a_out row 2 = A[2][1], row 4 = 0.
- Protection: wr_en and start asserted while busy → buffer contents unchanged; no second pass; a single done pulse.
- Reset mid-STREAM (cycle 6) → outputs go to 0 immediately; no done. A new start after release gives the full correct pass.
- Extremes: all operands 0xFF, DEPTH=8 → each row sum 8*65025 = 520200 (fits 24 bits). Back-to-back passes with start held high → two done pulses 19 cycles apart.
